data_memory_sync: RTL
=====================

Name: data_memory_sync

Overview:
- Synchronous, byte-addressed, little-endian data memory for the pipelined CPU MEM stage.
- Supports byte, half, word and (at DATA_W=64) double accesses, with sign/zero extension on loads.
- Adds a programmable wait-state count with a stall/ack handshake and an error flag for misaligned or out-of-range accesses.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 32 or 64.
- ADDR_W, 32, address bus width in bits.
- DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and ≥ DATA_W/8.
- LATENCY, 1, wait cycles between acceptance and completion; range 0–15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- MemRead_i  in  1  load request; held high until ack_o
- MemWrite_i  in  1  store request; held high until ack_o; wins over MemRead_i if both are high
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- sign_ext_i  in  1  1 = sign-extend load result, 0 = zero-extend
- addr_i  in  ADDR_W  byte address
- data_i  in  DATA_W  store data, taken from the low-order bytes
- data_o  out  DATA_W  load result
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  error flag, valid with ack_o
- stall_o  out  1  combinational: (MemRead_i|MemWrite_i) & ~ack_o

Behaviour:
- Clocking and reset are fixed: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE, wait counter 0, data_o 0, ack_o 0, err_o 0. Memory array is not cleared by reset.
- State machine:
  - IDLE: on a request, latch op, size, sign, addr and data. Go to BUSY with cnt=LATENCY-1 if LATENCY>0, otherwise go straight to RESP.
  - BUSY: decrement cnt each cycle; go to RESP when cnt==0.
  - RESP: ack_o=1 for exactly one cycle; return to IDLE.
- Latency: a request seen in IDLE at cycle 0 is acked at cycle LATENCY+1.
  - The next request is accepted in the cycle after ack, so back-to-back throughput is one access per LATENCY+2 cycles.
- Commit point: the store write and the load capture into data_o both occur on the edge entering RESP, using the latched fields.
- Input changes after acceptance have no effect on the access in progress.
- Load result:
  - Bytes are assembled {m[a+n-1]…m[a]}, little-endian.
  - The result is extended to DATA_W per sign_ext_i.
  - data_o holds its value until the next load completes; stores and errors do not change it.
- Store: writes exactly 1, 2, 4 or 8 bytes; other bytes are untouched.
- Error cases: misaligned address, i.e. (addr & (bytes-1)) != 0; address + bytes > DEPTH_BYTES; size 11 when DATA_W=32.
  - On error: no memory write occurs, data_o is unchanged, and ack_o fires with err_o=1 at normal latency.
- Address decoding: only addr_i[$clog2(DEPTH_BYTES)-1:0] indexes the array, and the range check uses the full address. There is no wrap-around.
- Simultaneous MemRead_i and MemWrite_i: performed as a store; no load takes place.
- Reset mid-operation: the access is aborted, no write is committed, and no ack_o is issued.
- A request dropped while in BUSY still completes and acks; the requester must not do this.

Optional Feature:
- Macro: DATA_MEMORY_STATS_EN.
- When defined, the block adds two ports:
  - rd_count_o  out  32: completed error-free loads.
  - wr_count_o  out  32: completed error-free stores.
- Both counters are cleared by rst_i, increment at RESP, and saturate at 32'hFFFFFFFF.
- When undefined, these ports and their registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package data_memory_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE.
  - Function size_bytes(size).
  - State enum IDLE/BUSY/RESP.
- Sub-module dmem_lane_align: purely combinational. Given size, sign_ext and raw little-endian bytes, it produces the extended load word and the alignment-error bit.

Test Plan:
- LATENCY=1: store word 0xDEADBEEF to addr 0x10, then load word from 0x10 → ack at cycle 2 after each request; data_o=0xDEADBEEF; err_o=0.
- After the above: load byte 0x13 with sign_ext=1 → 0xFFFFFFDE. Load half 0x10 with sign_ext=0 → 0x0000BEEF.
- Store byte 0x55 to 0x11, then load word 0x10 → 0xDEAD55EF; the other bytes are preserved.
- Misaligned and out-of-range:
  - Store word to 0x12 → err_o=1 with ack; a following word load of 0x10 still returns the old data.
  - Load word at DEPTH_BYTES-2 → err_o=1.
- LATENCY=3: assert rst_i for one cycle while in BUSY during a store of 0x12345678 to 0x20 → no ack; a later load of 0x20 returns the prior contents.
- With DATA_MEMORY_STATS_EN: 3 good loads, 2 good stores and 1 errored store → rd_count_o=3, wr_count_o=2.

Source files
------------

// File: rtl/data_memory_pkg.sv
`default_nettype none
// ==================================================================
// data_memory_pkg: size encodings, byte-count helper, FSM states.
// Revision: 1.0
// ==================================================================
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'd1;
            SZ_HALF: return 4'd2;
            SZ_WORD: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ==================================================================
// dmem_lane_align: extends raw little-endian load bytes, flags misalignment.
// Revision: 1.0
// ==================================================================
import data_memory_pkg::*;

module dmem_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [2:0]        addr_lo,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] load_data,
    output logic              align_err
);

    logic [3:0] nbytes;
    logic       fill;

    always_comb begin
        nbytes    = size_bytes(size);
        load_data = '0;
        case (size)
            SZ_BYTE: fill = raw[7];
            SZ_HALF: fill = raw[15];
            SZ_WORD: fill = raw[31];
            default: fill = raw[DATA_W-1];
        endcase
        fill = fill & sign_ext;
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < 8 * int'(nbytes)) ? raw[i] : fill;
        end
        align_err = |(addr_lo & 3'(nbytes - 4'd1));
        // A 32-bit bus has no double-width access
        if (size == SZ_DOUBLE && DATA_W == 32) begin
            align_err = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_sync.sv
`default_nettype none
// ==================================================================
// data_memory_sync: synchronous byte-addressed data memory with wait states.
// Optional macro DATA_MEMORY_STATS_EN adds rd_count_o / wr_count_o.
// Revision: 1.0
// ==================================================================
import data_memory_pkg::*;

module data_memory_sync #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              stall_o
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
`endif
);

    localparam int         NB       = DATA_W / 8;
    localparam int         IDX_W    = $clog2(DEPTH_BYTES);
    localparam int         AW1      = ADDR_W + 1;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic       ZERO_LAT = (LATENCY == 0);

    logic [7:0]        mem [DEPTH_BYTES];

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic              lat_sx;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;

    logic              req;
    logic              acc_wr;
    logic [1:0]        acc_size;
    logic              acc_sx;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [3:0]        nbytes;
    logic [IDX_W-1:0]  idx;
    logic [AW1-1:0]    end_addr;
    logic              range_err;
    logic              align_err;
    logic              acc_err;
    logic              commit;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] load_data;

    assign req     = MemRead_i | MemWrite_i;
    assign stall_o = req & ~ack_o;

    // With zero wait states the commit edge is also the accept edge,
    // so the access fields come straight from the ports in IDLE.
    always_comb begin
        acc_wr   = (state == IDLE) ? MemWrite_i : lat_wr;
        acc_size = (state == IDLE) ? size_i     : lat_size;
        acc_sx   = (state == IDLE) ? sign_ext_i : lat_sx;
        acc_addr = (state == IDLE) ? addr_i     : lat_addr;
        acc_data = (state == IDLE) ? data_i     : lat_data;
    end

    assign nbytes    = size_bytes(acc_size);
    assign idx       = acc_addr[IDX_W-1:0];
    assign end_addr  = {1'b0, acc_addr} + AW1'(nbytes);
    assign range_err = end_addr > AW1'(DEPTH_BYTES);
    assign acc_err   = align_err | range_err;
    assign commit    = ~rst_i & (((state == IDLE) & req & ZERO_LAT) |
                                 ((state == BUSY) & (cnt == 4'd0)));

    always_comb begin
        raw = '0;
        for (int i = 0; i < NB; i++) begin
            raw[8*i +: 8] = mem[idx + IDX_W'(i)];
        end
    end

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .size      (acc_size),
        .sign_ext  (acc_sx),
        .addr_lo   (acc_addr[2:0]),
        .raw       (raw),
        .load_data (load_data),
        .align_err (align_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            data_o <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            ack_o <= commit;
            err_o <= commit & acc_err;
            if (commit && !acc_wr && !acc_err) begin
                data_o <= load_data;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_wr   <= MemWrite_i;
                        lat_size <= size_i;
                        lat_sx   <= sign_ext_i;
                        lat_addr <= addr_i;
                        lat_data <= data_i;
                        cnt      <= CNT_INIT;
                        state    <= ZERO_LAT ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; commit already excludes the reset cycle.
    always_ff @(posedge clk_i) begin
        if (commit && acc_wr && !acc_err) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < nbytes) begin
                    mem[idx + IDX_W'(i)] <= acc_data[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_MEMORY_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count_o <= 32'd0;
            wr_count_o <= 32'd0;
        end else if (commit && !acc_err) begin
            if (acc_wr) begin
                if (wr_count_o != 32'hFFFF_FFFF) wr_count_o <= wr_count_o + 32'd1;
            end else begin
                if (rd_count_o != 32'hFFFF_FFFF) rd_count_o <= rd_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
